switch_debounce_ctrl: RTL and testbench

//  Multi-channel front end for the board slide switches. It synchronises and debounces each

---
 rtl/switch_debounce_ctrl.sv | 77 +++++++
 tb/tb_switch_debounce_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/switch_debounce_ctrl.sv
// Multi-channel slide-switch front end: 2-flop sync, per-channel debounce,
// rise/fall strobes and LEVEL/TOGGLE output modes.
module switch_debounce_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SWITCHES,
    input  logic             MODE,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d  = SWITCHES;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // A bounce back to the accepted level restarts the count.
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        stable_dly_d = stable_q;
        rise_d       = stable_q & ~stable_dly_q;
        fall_d       = ~stable_q & stable_dly_q;
        out_d        = MODE ? (out_q ^ rise_d) : stable_q;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            out_q        <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            cnt_q        <= '{default: '0};
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            out_q        <= out_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4;
// expected values are hand-derived edge by edge.
module tb_switch_debounce_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       mode;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;

    int n_chk;
    int n_fail;

    switch_debounce_ctrl #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK    (clk),
        .RESET_N  (rst_n),
        .SWITCHES (sw),
        .MODE     (mode),
        .out      (out),
        .rise     (rise),
        .fall     (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got,
                         input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got out/rise/fall=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe lands on edge n after the stimulus; quiet before and after it.
    task automatic wait_strobe(input string tag, input int n,
                               input logic [3:0] o_pre, input logic [3:0] o_post,
                               input logic [3:0] r_exp, input logic [3:0] f_exp);
        for (int e = 1; e < n; e++) begin
            step(1);
            check({tag, "_pre"}, {out, rise, fall}, {o_pre, 4'h0, 4'h0});
        end
        step(1);
        check({tag, "_hit"}, {out, rise, fall}, {o_post, r_exp, f_exp});
        step(1);
        check({tag, "_post"}, {out, rise, fall}, {o_post, 4'h0, 4'h0});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        sw     = 4'hF;
        mode   = 1'b1;

        // 1: reset with switches high, then release in LEVEL
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset", {out, rise, fall}, 12'h000);
        end
        rst_n = 1'b1;
        mode  = 1'b0;
        wait_strobe("rel_rise", 7, 4'h0, 4'hF, 4'hF, 4'h0);

        sw = 4'h0;
        wait_strobe("all_fall", 7, 4'hF, 4'h0, 4'h0, 4'hF);

        // 2: clean rise on channel 0
        sw = 4'h1;
        wait_strobe("lvl_rise0", 7, 4'h0, 4'h1, 4'h1, 4'h0);

        // 3: channel 1 bounces (2-clk phases), then holds high
        for (int k = 0; k < 4; k++) begin
            sw[1] = ~k[0];
            for (int j = 0; j < 2; j++) begin
                step(1);
                check("bounce", {out, rise, fall}, {4'h1, 4'h0, 4'h0});
            end
        end
        sw[1] = 1'b1;
        wait_strobe("bounce_rise", 7, 4'h1, 4'h3, 4'h2, 4'h0);

        // 4: TOGGLE on channel 2
        mode = 1'b1;
        sw   = 4'h7;
        wait_strobe("tg_p1", 7, 4'h3, 4'h7, 4'h4, 4'h0);
        sw = 4'h3;
        wait_strobe("tg_r1", 7, 4'h7, 4'h7, 4'h0, 4'h4);
        sw = 4'h7;
        wait_strobe("tg_p2", 7, 4'h7, 4'h3, 4'h4, 4'h0);
        sw = 4'h3;
        wait_strobe("tg_r2", 7, 4'h3, 4'h3, 4'h0, 4'h4);
        sw = 4'h7;
        wait_strobe("tg_p3", 7, 4'h3, 4'h7, 4'h4, 4'h0);
        sw = 4'h3;
        wait_strobe("tg_r3", 7, 4'h7, 4'h7, 4'h0, 4'h4);

        // 5: out[3]=1 with switch 3 low, then back to LEVEL
        sw = 4'hB;
        wait_strobe("tg_p4", 7, 4'h7, 4'hF, 4'h8, 4'h0);
        sw = 4'h3;
        wait_strobe("tg_r4", 7, 4'hF, 4'hF, 4'h0, 4'h8);
        mode = 1'b0;
        step(1);
        check("mode_lvl", {out, rise, fall}, {4'h3, 4'h0, 4'h0});
        step(1);
        check("mode_lvl2", {out, rise, fall}, {4'h3, 4'h0, 4'h0});

        // 6: reset mid-count on channel 0
        sw = 4'h2;
        wait_strobe("pre6_fall", 7, 4'h3, 4'h2, 4'h0, 4'h1);
        sw = 4'h3;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("midcnt", {out, rise, fall}, {4'h2, 4'h0, 4'h0});
        end
        rst_n = 1'b0;
        step(1);
        check("mid_reset", {out, rise, fall}, 12'h000);
        rst_n = 1'b1;
        wait_strobe("restart", 7, 4'h0, 4'h3, 4'h3, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
